kamus_lsu: RTL and testbench

//  Load/store unit on the consumer side of the control-unit decision bus.

---
 rtl/kamus_lsu.sv | 159 +++++++++++++++
 tb/tb_kamus_lsu.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/kamus_lsu.sv
// Load/store unit: single-outstanding L1D access over a req/gnt/rvalid port,
// with store lane alignment, load extension and an abort timer.
module kamus_lsu #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              mem_req_i,
    input  logic              l1d_wr_en_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              misalign_o,
    output logic              timeout_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        legal;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] ld_word;
    logic [31:0] ld_ext;
    logic        cnt_last;

    assign cnt_last = (cnt == 8'(TIMEOUT - 1));

    always_comb begin
        legal   = 1'b0;
        be_n    = 4'b0000;
        wdata_n = wdata_i;
        case (funct3_i)
            3'b000, 3'b100: begin
                legal   = 1'b1;
                be_n    = 4'b0001 << addr_i[1:0];
                wdata_n = {4{wdata_i[7:0]}};
            end
            3'b001, 3'b101: begin
                legal   = ~addr_i[0];
                be_n    = 4'b0011 << {addr_i[1], 1'b0};
                wdata_n = {2{wdata_i[15:0]}};
            end
            3'b010: begin
                legal = (addr_i[1:0] == 2'b00);
                be_n  = 4'b1111;
            end
            default: legal = 1'b0;
        endcase
    end

    // Extension uses the offset latched at accept time, not the live address.
    always_comb begin
        ld_word = dmem_rdata_i >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
            3'b100:  ld_ext = {24'b0, ld_word[7:0]};
            3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
            3'b101:  ld_ext = {16'b0, ld_word[15:0]};
            default: ld_ext = dmem_rdata_i;
        endcase
    end

    assign stall_o = ((state == IDLE) & mem_req_i & legal) | (state == REQ) | (state == WAIT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            cnt          <= '0;
            f3_q         <= '0;
            off_q        <= '0;
            done_o       <= 1'b0;
            rdata_o      <= '0;
            misalign_o   <= 1'b0;
            timeout_o    <= 1'b0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
        end else begin
            done_o     <= 1'b0;
            misalign_o <= 1'b0;
            timeout_o  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (mem_req_i) begin
                        if (legal) begin
                            state        <= REQ;
                            f3_q         <= funct3_i;
                            off_q        <= addr_i[1:0];
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= l1d_wr_en_i;
                            dmem_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                            dmem_be_o    <= be_n;
                            dmem_wdata_o <= wdata_n;
                        end else begin
                            misalign_o <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        cnt        <= '0;
                        if (dmem_rvalid_i) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                            if (!dmem_we_o) rdata_o <= ld_ext;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (cnt_last) begin
                        dmem_req_o <= 1'b0;
                        cnt        <= '0;
                        state      <= DONE;
                        timeout_o  <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid_i) begin
                        cnt    <= '0;
                        state  <= DONE;
                        done_o <= 1'b1;
                        if (!dmem_we_o) rdata_o <= ld_ext;
                    end else if (cnt_last) begin
                        cnt       <= '0;
                        state     <= DONE;
                        timeout_o <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_kamus_lsu.sv
// Scoreboard bench for kamus_lsu: the bench plays the pipeline and the L1D.
module tb_kamus_lsu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall, done, misalign, timeout;
    logic [31:0] rdata;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    kamus_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(mem_req), .l1d_wr_en_i(wr_en),
        .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata), .stall_o(stall),
        .done_o(done), .rdata_o(rdata), .misalign_o(misalign), .timeout_o(timeout),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
        .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata), .dmem_gnt_i(gnt),
        .dmem_rvalid_i(rvalid), .dmem_rdata_i(dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_rdata(input string tag);
        if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        else chk(tag, rdata, exp_q.pop_front());
    endtask

    // same=1: gnt and rvalid arrive together; otherwise rvalid one cycle after gnt.
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rword,
                             input logic [3:0] ebe, input logic [31:0] ewd,
                             input logic [31:0] erd, input int gdly, input bit same);
        exp_q.push_back(erd);
        mem_req = 1'b1; wr_en = we; funct3 = f3; addr = a; wdata = wd;
        #1;
        chk("stall_idle", 32'(stall), 32'd1);
        step();
        chk("req", 32'(dmem_req), 32'd1);
        chk("addr", dmem_addr, {a[31:2], 2'b00});
        chk("be", 32'(dmem_be), 32'(ebe));
        chk("we", 32'(dmem_we), 32'(we));
        chk("wdata", dmem_wdata, ewd);
        for (int i = 0; i < gdly; i++) begin
            step();
            chk("req_hold", 32'(dmem_req), 32'd1);
            chk("addr_hold", dmem_addr, {a[31:2], 2'b00});
            chk("wdata_hold", dmem_wdata, ewd);
            chk("stall_hold", 32'(stall), 32'd1);
        end
        gnt = 1'b1;
        if (same) begin
            rvalid = 1'b1;
            dmem_rdata = rword;
        end
        step();
        gnt = 1'b0;
        if (!same) begin
            chk("req_drop", 32'(dmem_req), 32'd0);
            chk("stall_wait", 32'(stall), 32'd1);
            chk("done_early", 32'(done), 32'd0);
            rvalid = 1'b1;
            dmem_rdata = rword;
            step();
        end
        rvalid = 1'b0;
        dmem_rdata = 32'h5A5A_5A5A;
        chk("done", 32'(done), 32'd1);
        chk("stall_done", 32'(stall), 32'd0);
        chk("timeout_ok", 32'(timeout), 32'd0);
        pop_rdata("rdata");
        mem_req = 1'b0;
        step();
        chk("done_pulse", 32'(done), 32'd0);
    endtask

    task automatic bad_access(input logic [2:0] f3, input logic [31:0] a);
        mem_req = 1'b1; wr_en = 1'b0; funct3 = f3; addr = a;
        #1;
        chk("mis_stall", 32'(stall), 32'd0);
        step();
        chk("mis_pulse", 32'(misalign), 32'd1);
        chk("mis_noreq", 32'(dmem_req), 32'd0);
        mem_req = 1'b0;
        step();
        chk("mis_clear", 32'(misalign), 32'd0);
        chk("mis_noreq2", 32'(dmem_req), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, 32'(dmem_req), 32'd0);
        chk({tag, "_we"}, 32'(dmem_we), 32'd0);
        chk({tag, "_addr"}, dmem_addr, 32'd0);
        chk({tag, "_be"}, 32'(dmem_be), 32'd0);
        chk({tag, "_wdata"}, dmem_wdata, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_flags"}, {28'd0, done, misalign, timeout, stall}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #12;
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        do_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF, 0, 1'b0);
        do_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFF7F, 4'b1000, 32'h0, 32'hFFFFFF80, 0, 1'b0);
        do_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFF7F, 4'b1000, 32'h0, 32'h00000080, 0, 1'b0);
        do_access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 4'b1100, 32'hABCDABCD, 32'h00000080, 5, 1'b0);
        do_access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 4'b1100, 32'h0, 32'hFFFF8001, 0, 1'b1);
        do_access(1'b0, 3'b101, 32'h100, 32'h0, 32'h1234F00D, 4'b0011, 32'h0, 32'h0000F00D, 2, 1'b0);
        do_access(1'b1, 3'b000, 32'h101, 32'h00000055, 32'h0, 4'b0010, 32'h55555555, 32'h0000F00D, 0, 1'b1);
        do_access(1'b1, 3'b010, 32'h300, 32'hCAFEBABE, 32'h0, 4'b1111, 32'hCAFEBABE, 32'h0000F00D, 1, 1'b0);
        do_access(1'b0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 4'b0010, 32'h0, 32'h0000007F, 0, 1'b0);

        bad_access(3'b010, 32'h101);
        bad_access(3'b001, 32'h103);
        bad_access(3'b011, 32'h100);

        // Granted load whose response never comes.
        exp_q.push_back(32'h0000007F);
        mem_req = 1'b1; wr_en = 1'b0; funct3 = 3'b010; addr = 32'h400;
        step();
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        n = 0;
        while (!timeout && n < 300) begin
            step();
            n++;
        end
        chk("to_seen", 32'(timeout), 32'd1);
        chk("to_cycles", n, 32'd255);
        chk("to_done", 32'(done), 32'd0);
        chk("to_stall", 32'(stall), 32'd0);
        pop_rdata("to_rdata");
        mem_req = 1'b0;
        step();
        chk("to_pulse", 32'(timeout), 32'd0);
        chk("to_idle", {30'd0, stall, dmem_req}, 32'd0);

        // Reset while waiting for the response.
        mem_req = 1'b1; wr_en = 1'b0; funct3 = 3'b010; addr = 32'h500;
        step();
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("wait_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        mem_req = 1'b0;
        #1;
        chk_all_zero("rst_wait");
        step();
        rst_n = 1'b1;
        step();

        // Reset while the request is still on the bus.
        mem_req = 1'b1; wr_en = 1'b1; funct3 = 3'b010; addr = 32'h600; wdata = 32'h11223344;
        step();
        chk("rst_req_pre", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        mem_req = 1'b0;
        #1;
        chk_all_zero("rst_req");
        step();
        rst_n = 1'b1;
        step();
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
